// File: rtl/add_round_key_seq_pkg.sv
// add_round_key_seq_pkg: shared AES sizes and sequencer FSM encoding
package add_round_key_seq_pkg;
    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_BYTES = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;
endpackage

// File: rtl/add_round_key_seq_gf_adder.sv
// add_round_key_seq_gf_adder: 8-bit GF(2^8) adder; ports a_i, b_i in, sum_o = a_i + b_i (carry-free)
module add_round_key_seq_gf_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o
);
    assign sum_o = a_i ^ b_i;
endmodule

// File: rtl/add_round_key_seq.sv
// add_round_key_seq: byte-serial AES AddRoundKey, LANES time-shared GF adders over 16/LANES RUN cycles
//   clk, rst_n (async, active-low), clear (sync abort)
//   in_valid/in_ready with state_in/key_in; out_valid/out_ready with state_out; busy while running
module add_round_key_seq
    import add_round_key_seq_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] state_in,
    input  logic [AES_BLOCK_BITS-1:0] key_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLOCK_BITS-1:0] state_out,
    output logic                      busy
);
    localparam int N = AES_BYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("add_round_key_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_e                      fsm_q;
    logic [CW-1:0]             cnt_q;
    logic [AES_BYTES-1:0][7:0] st_q, key_q, st_d;
    logic [LANES-1:0][7:0]     sum;
    logic [LANES-1:0][3:0]     idx;

    // Byte 0 is the most significant byte, i.e. packed element AES_BYTES-1.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign idx[j] = 4'(AES_BYTES - 1 - int'(cnt_q) * LANES - j);
        add_round_key_seq_gf_adder u_gf_adder (
            .a_i  (st_q[idx[j]]),
            .b_i  (key_q[idx[j]]),
            .sum_o(sum[j])
        );
    end

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < LANES; i++) st_d[idx[i]] = sum[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
            key_q <= '0;
        end else if (clear) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    st_q  <= state_in;
                    key_q <= key_in;
                    cnt_q <= '0;
                    fsm_q <= RUN;
                end
                RUN: begin
                    st_q  <= st_d;
                    cnt_q <= (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
                    fsm_q <= (cnt_q == CW'(N - 1)) ? DONE : RUN;
                end
                DONE: if (out_ready) fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = fsm_q == IDLE;
    assign busy      = fsm_q == RUN;
    assign out_valid = fsm_q == DONE;
    assign state_out = st_q;
endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq: directed self-checking bench for add_round_key_seq with LANES = 1, 4 and 16
module tb_add_round_key_seq;
    localparam logic [127:0] S_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] X_A  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] S_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B  = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    localparam logic [127:0] X_B  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] S_C  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] K_C  = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] X_C  = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] ONES = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ZERO = 128'h0;

    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0, v4 = 0, v16 = 0;
    logic [127:0] state_in = '0, key_in = '0;
    logic in_ready, out_valid, busy, r4, ov4, b4, r16, ov16, b16;
    logic [127:0] state_out, so4, so16;
    int n_chk = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_round_key_seq #(.LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );
    add_round_key_seq #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v4), .in_ready(r4),
        .state_in(state_in), .key_in(key_in), .out_valid(ov4), .out_ready(1'b1),
        .state_out(so4), .busy(b4)
    );
    add_round_key_seq #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v16), .in_ready(r16),
        .state_in(state_in), .key_in(key_in), .out_valid(ov16), .out_ready(1'b1),
        .state_out(so16), .busy(b16)
    );

    task automatic run1(input logic [127:0] s, input logic [127:0] k, input logic [127:0] x, input string name);
        int lat, bc;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: in_ready=%b, required 1", name, in_ready);
        end
        state_in = s;
        key_in = k;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        bc = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            lat++;
            @(negedge clk);
        end
        n_chk++;
        if (lat != 16) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required 16", name, lat);
        end
        n_chk++;
        if (bc != 16) begin
            n_fail++;
            $display("FAIL %s busy: high for %0d cycles, required 16", name, bc);
        end
        n_chk++;
        if (state_out !== x) begin
            n_fail++;
            $display("FAIL %s result: state_out=%h, required %h", name, state_out, x);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== ZERO) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b state_out=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fips;
        run1(S_A, K_A, X_A, "fips_l1");
    endtask

    task automatic test_lanes;
        for (int p = 0; p < 2; p++) begin
            int el, lat;
            el = (p == 1) ? 1 : 4;
            lat = 0;
            state_in = S_A;
            key_in = K_A;
            if (p == 1) v16 = 1;
            else v4 = 1;
            @(negedge clk);
            v4 = 0;
            v16 = 0;
            while (((p == 1) ? ov16 : ov4) !== 1'b1 && lat < 40) begin
                lat++;
                @(negedge clk);
            end
            n_chk++;
            if (lat != el) begin
                n_fail++;
                $display("FAIL lanes%0d latency: got %0d, required %0d", el == 1 ? 16 : 4, lat, el);
            end
            n_chk++;
            if (((p == 1) ? so16 : so4) !== X_A) begin
                n_fail++;
                $display("FAIL lanes%0d result: state_out=%h, required %h", el == 1 ? 16 : 4,
                         (p == 1) ? so16 : so4, X_A);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_edges;
        run1(ONES, ONES, ZERO, "ff_xor_ff");
        run1(ONES, ZERO, ONES, "ff_xor_00");
    endtask

    task automatic test_backpressure;
        int lat;
        state_in = S_A;
        key_in = K_A;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        n_chk++;
        if (lat != 16) begin
            n_fail++;
            $display("FAIL bp first latency: got %0d, required 16", lat);
        end
        state_in = S_B;
        key_in = K_B;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== X_A) begin
                n_fail++;
                $display("FAIL bp hold %0d: out_valid=%b in_ready=%b state_out=%h, required 1 0 %h",
                         i, out_valid, in_ready, state_out, X_A);
            end
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        in_valid = 0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp accept: busy=%b, required 1", busy);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        n_chk++;
        if (lat != 16 || state_out !== X_B) begin
            n_fail++;
            $display("FAIL bp second: latency %0d state_out=%h, required 16 %h", lat, state_out, X_B);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_clear;
        int seen;
        state_in = S_C;
        key_in = K_C;
        in_valid = 1;
        clear = 1;
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear vs handshake: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        state_in = S_A;
        key_in = K_A;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear pre: busy=%b, required 1", busy);
        end
        clear = 1;
        @(negedge clk);
        clear = 0;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear abort: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        seen = 0;
        repeat (20) begin
            if (out_valid === 1'b1) seen = 1;
            @(negedge clk);
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL clear no output: out_valid rose=%0d, required 0", seen);
        end
        run1(S_C, K_C, X_C, "after_clear");
    endtask

    task automatic test_async_reset;
        state_in = S_B;
        key_in = K_B;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== ZERO) begin
            n_fail++;
            $display("FAIL async reset: in_ready=%b out_valid=%b busy=%b state_out=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post reset: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] sv[3], kv[3], xv[3];
        int acc[3];
        int idx, na, got, pend;
        sv = '{S_A, S_B, S_C};
        kv = '{K_A, K_B, K_C};
        xv = '{X_A, X_B, X_C};
        acc = '{0, 0, 0};
        out_ready = 1;
        state_in = sv[0];
        key_in = kv[0];
        in_valid = 1;
        idx = 1;
        na = 0;
        got = 0;
        pend = 0;
        for (int t = 0; t < 100 && got < 3; t++) begin
            if (pend != 0) begin
                if (idx < 3) begin
                    state_in = sv[idx];
                    key_in = kv[idx];
                    idx++;
                end else in_valid = 0;
                pend = 0;
            end
            if (out_valid === 1'b1) begin
                n_chk++;
                if (state_out !== xv[got]) begin
                    n_fail++;
                    $display("FAIL b2b result %0d: state_out=%h, required %h", got, state_out, xv[got]);
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1 && na < 3) begin
                acc[na] = cyc;
                na++;
                pend = 1;
            end
            @(negedge clk);
        end
        out_ready = 0;
        in_valid = 0;
        n_chk++;
        if (got != 3 || na != 3) begin
            n_fail++;
            $display("FAIL b2b count: results %0d accepts %0d, required 3 3", got, na);
        end
        n_chk++;
        if (acc[1] - acc[0] != 18 || acc[2] - acc[1] != 18) begin
            n_fail++;
            $display("FAIL b2b spacing: %0d %0d cycles, required 18 18", acc[1] - acc[0], acc[2] - acc[1]);
        end
    endtask

    initial begin
        test_reset;
        test_fips;
        test_lanes;
        test_edges;
        test_backpressure;
        test_clear;
        test_async_reset;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/add_round_key_seq.md
# add_round_key_seq

Byte-serial AddRoundKey sequencer for the AES datapath. It accepts a 128-bit state and a 128-bit round key over a valid/ready handshake, then time-shares `LANES` instances of the 8-bit GF(2^8) adder across the 16 state bytes. It returns the 128-bit result over a second valid/ready handshake. It sits between the round-key source and the SubBytes stage and lets area be traded for latency.

## Interface
- `LANES`, default 1: number of GF adders used in parallel.
  - Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
  - `N = 16/LANES` is the number of RUN cycles.
- `clk`, input, 1 bit: single clock; all flops are rising-edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `clear`, input, 1 bit: synchronous abort. It has priority over all other inputs.
- `in_valid`, input, 1 bit: `state_in` and `key_in` are valid.
- `in_ready`, output, 1 bit: the block can accept a new input.
- `state_in`, input, 128 bits: AES state. Byte 0 is bits [127:120]; byte 15 is bits [7:0].
- `key_in`, input, 128 bits: round key, using the same byte order.
- `out_valid`, output, 1 bit: `state_out` holds a finished result.
- `out_ready`, output consumer, input, 1 bit: the downstream block accepts the result.
- `state_out`, output, 128 bits: `state_in` XOR `key_in`, byte-aligned.
- `busy`, output, 1 bit: high while in RUN.

## Operation
- Registers:
  - `st_q[127:0]`: captured state, overwritten in place.
  - `key_q[127:0]`: captured key.
  - Chunk counter `cnt`, width clog2(N) with a minimum of 1 bit.
  - FSM state.
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture `state_in` into `st_q` and `key_in` into `key_q`, set `cnt` = 0, go to RUN.
- **RUN**
  - Each cycle, bytes `cnt*LANES` through `cnt*LANES+LANES-1` of `st_q` are replaced with `st_q` byte XOR `key_q` byte, through the GF adder lanes.
  - `cnt` increments each cycle.
  - When `cnt == N-1`, go to DONE.
  - `in_valid` is ignored in RUN.
- **DONE**
  - `out_valid` = 1 and `state_out` = `st_q`; both are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- **Outputs**
  - `in_ready` = (FSM == IDLE).
  - `busy` = (FSM == RUN).
  - `out_valid` = (FSM == DONE).
  - `state_out` is driven from `st_q` at all times; it is only meaningful while `out_valid` is high.
- **`clear`**
  - The next edge forces IDLE and `cnt` = 0, from any state.
  - A handshake presented in the same cycle as `clear` is not taken.
- **Reset (`rst_n` low, at any time including mid-RUN)**
  - Immediately forces IDLE, `cnt` = 0, `st_q` = 0 and `key_q` = 0.
  - Reset values of outputs: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `state_out` = 0.
- Width rules: 8-bit lanes, XOR only, no carries, no overflow.

## Timing
- Input handshake at edge E. RUN occupies edges E+1 through E+N. `out_valid` rises after edge E+N, which is a latency of N cycles.
  - LANES = 1 gives 16 cycles.
  - LANES = 16 gives 1 cycle.
- Output handshake at edge F: `out_valid` falls and `in_ready` rises after F.
  - Earliest F is E+N+1.
  - Next earliest accept is F+1.
  - Peak throughput is therefore one block per N+2 cycles.
- Backpressure: `out_ready` held low keeps DONE indefinitely, with `state_out` unchanged.
- `in_ready` is low from E through F, so no input is lost or overwritten.

## Structure
- Shared include `aes_defs.vh` holds:
  - `AES_BLOCK_BITS` = 128 and `AES_BYTES` = 16.
  - FSM state encodings IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- Sub-module: the existing 8-bit `GF_Adder`, instantiated `LANES` times through a generate loop.
  - Lane j reads byte `cnt*LANES+j` of `st_q` and `key_q`.
- Target size: about 150 lines of RTL.

## Test plan
- **FIPS-197 vector (Appendix B, round-0 AddRoundKey), LANES = 1**
  - Stimulus: state = 3243f6a8885a308d313198a2e0370734, key = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `out_valid` exactly 16 cycles after accept, `state_out` = 193de3bea0f4e22b9ac68d2ae9f84808, `busy` high for exactly 16 cycles.
- **Same vector with LANES = 4 and LANES = 16**
  - Required: identical result, with latencies of 4 and 1 cycles.
- **Backpressure**
  - Stimulus: hold `out_ready` = 0 for 10 cycles after `out_valid` rises, and drive `in_valid` = 1 with a new vector throughout.
  - Required: `state_out` stable; `in_ready` = 0; the new vector is accepted only on the cycle after `out_ready` = 1.
- **Edge values**
  - Stimulus 1: state = all FF, key = all FF. Required: `state_out` = 0.
  - Stimulus 2: state = all FF, key = 0. Required: `state_out` = all FF.
- **Mid-operation `clear` and `rst_n`**
  - Stimulus: assert `clear` at RUN cycle 7 (LANES = 1), then apply a fresh vector.
    - Required: IDLE on the next edge; `out_valid` never rises for the aborted block; the fresh vector gives the correct result after 16 cycles.
  - Stimulus: pulse `rst_n` low asynchronously mid-RUN.
    - Required: outputs go to their reset values immediately.
- **Back-to-back operation**
  - Stimulus: three vectors with `out_ready` tied to 1.
  - Required: accepts spaced exactly N+2 cycles apart, and all three results correct.
